// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: sequencer state encoding, default timing constants and a width helper
package pll_seq_pkg;
  typedef enum logic [2:0] {PULSE, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT} state_t;
  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_RELEASE_STAGGER     = 8;
  localparam int unsigned DEF_MAX_RETRIES         = 3;
  function automatic int unsigned max3(input int unsigned a, input int unsigned b, input int unsigned c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic 2-flop bit synchronizer (i_clk, i_rst sync active-high, i_d async in, o_q synchronized out)
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_sync;
  always_ff @(posedge i_clk) r_sync <= i_rst ? 2'b00 : {r_sync[0], i_d};
  assign o_q = r_sync[1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset pulse, lock qualification and ordered sys/periph reset release on i_refclk; outputs o_pll_rst/o_sys_rst/o_periph_rst/o_ready/o_fault/o_retry_cnt/o_unlock_cnt
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned RELEASE_STAGGER     = DEF_RELEASE_STAGGER,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       i_refclk,
  input  logic       i_rst,
  input  logic       i_pll_locked,
  input  logic       i_relock_req,
  output logic       o_pll_rst,
  output logic       o_sys_rst,
  output logic       o_periph_rst,
  output logic       o_ready,
  output logic       o_fault,
  output logic [3:0] o_retry_cnt,
  output logic [7:0] o_unlock_cnt
);
  localparam int CW = $clog2(max3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, RELEASE_STAGGER) + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  logic          w_lock_s;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_retry, w_retry;
  logic [7:0]    r_unlock;
  logic          w_unlock_inc, w_tmo, w_enter, w_tkeep;
  logic          r_pll_rst, r_sys_rst, r_periph_rst, r_ready, r_fault;
  sync_2ff u_lock_sync (
    .i_clk (i_refclk),
    .i_rst (i_rst),
    .i_d   (i_pll_locked),
    .o_q   (w_lock_s)
  );
  always_comb begin
    w_next       = r_state;
    w_retry      = r_retry;
    w_unlock_inc = 1'b0;
    w_tmo        = r_tcnt >= TW'(LOCK_TIMEOUT_CYCLES - 1);
    if (i_relock_req) begin
      w_next  = PULSE;
      w_retry = 4'd0;
    end else begin
      case (r_state)
        PULSE:     w_next = (r_cnt == CW'(RST_PULSE_CYCLES - 1)) ? WAIT_LOCK : PULSE;
        WAIT_LOCK: begin
          if (w_lock_s) w_next = STABLE;
          else if (w_tmo) begin
            w_retry = r_retry + 4'd1;
            w_next  = (r_retry + 4'd1 == 4'(MAX_RETRIES)) ? FAULT : PULSE;
          end
        end
        STABLE:    w_next = !w_lock_s ? WAIT_LOCK : (r_cnt == CW'(LOCK_STABLE_CYCLES - 1)) ? RELEASE : STABLE;
        RELEASE:   w_next = !w_lock_s ? PULSE : (r_cnt == CW'(RELEASE_STAGGER - 1)) ? RUN : RELEASE;
        RUN: begin
          w_next       = w_lock_s ? RUN : PULSE;
          w_unlock_inc = !w_lock_s;
        end
        FAULT:     w_next = FAULT;
        default:   w_next = PULSE;
      endcase
    end
    w_enter = i_relock_req || (w_next != r_state);
    // the timeout budget spans the whole WAIT_LOCK/STABLE episode, so hopping between them keeps it
    w_tkeep = !i_relock_req && ((r_state == STABLE && w_next == WAIT_LOCK) || (r_state == WAIT_LOCK && w_next == STABLE));
  end
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_state      <= PULSE;
      r_cnt        <= '0;
      r_tcnt       <= '0;
      r_retry      <= 4'd0;
      r_unlock     <= 8'd0;
      r_pll_rst    <= 1'b1;
      r_sys_rst    <= 1'b1;
      r_periph_rst <= 1'b1;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_enter ? '0 : r_cnt + CW'(1);
      r_tcnt       <= (w_enter && !w_tkeep) ? '0 : w_tmo ? r_tcnt : r_tcnt + TW'(1);
      r_retry      <= w_retry;
      r_unlock     <= r_unlock + 8'(w_unlock_inc && r_unlock != 8'hFF);
      // outputs decode the next state so they change on the same edge as the state register
      r_pll_rst    <= w_next == PULSE || w_next == FAULT;
      r_sys_rst    <= !(w_next == RELEASE || w_next == RUN);
      r_periph_rst <= w_next != RUN;
      r_ready      <= w_next == RUN;
      r_fault      <= w_next == FAULT;
    end
  end
  assign o_pll_rst    = r_pll_rst;
  assign o_sys_rst    = r_sys_rst;
  assign o_periph_rst = r_periph_rst;
  assign o_ready      = r_ready;
  assign o_fault      = r_fault;
  assign o_retry_cnt  = r_retry;
  assign o_unlock_cnt = r_unlock;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: event-scoreboard bench for reset release timing, retries, fault, relock and loss of lock
module tb_pll_reset_sequencer;
  localparam int RP = 4, ST = 8, TO = 32, SG = 3, MR = 2;
  localparam logic [16:0] RST_V = {3'b111, 14'd0};
  logic clk = 1'b0, rst = 1'b1, lk = 1'b0, rq = 1'b0;
  logic o_pll_rst, o_sys_rst, o_periph_rst, o_ready, o_fault;
  logic [3:0] o_retry_cnt;
  logic [7:0] o_unlock_cnt;
  logic [16:0] w_all;
  typedef struct {int sig; logic val; int e;} ev_t;
  ev_t sb[$], obs[$];
  int edge_n = 0, checks = 0, errors = 0, b = 0;
  logic p0 = 1'b1, p1 = 1'b1, p2 = 1'b1;
  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(RP), .LOCK_STABLE_CYCLES(ST), .LOCK_TIMEOUT_CYCLES(TO),
    .RELEASE_STAGGER(SG), .MAX_RETRIES(MR)
  ) dut (
    .i_refclk(clk), .i_rst(rst), .i_pll_locked(lk), .i_relock_req(rq),
    .o_pll_rst(o_pll_rst), .o_sys_rst(o_sys_rst), .o_periph_rst(o_periph_rst),
    .o_ready(o_ready), .o_fault(o_fault), .o_retry_cnt(o_retry_cnt), .o_unlock_cnt(o_unlock_cnt)
  );
  assign w_all = {o_pll_rst, o_sys_rst, o_periph_rst, o_ready, o_fault, o_retry_cnt, o_unlock_cnt};
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  function automatic ev_t mk(input int s, input logic v, input int e);
    ev_t t;
    t.sig = s;
    t.val = v;
    t.e = e;
    return t;
  endfunction
  // reset outputs are logged as (0=pll,1=sys,2=periph) transitions tagged with the edge that caused them
  always @(negedge clk) begin
    if (o_pll_rst !== p0) obs.push_back(mk(0, o_pll_rst, edge_n));
    if (o_sys_rst !== p1) obs.push_back(mk(1, o_sys_rst, edge_n));
    if (o_periph_rst !== p2) obs.push_back(mk(2, o_periph_rst, edge_n));
    p0 = o_pll_rst;
    p1 = o_sys_rst;
    p2 = o_periph_rst;
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic wait_to(input int e);
    while (edge_n < e) tick();
  endtask
  task automatic expect_ev(input int s, input logic v, input int e);
    sb.push_back(mk(s, v, e));
  endtask
  task automatic drain_until(input int e);
    ev_t x, y;
    wait_to(e);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      if (obs.size() == 0) begin
        errors++;
        $display("FAIL event_missing: nothing observed, required sig %0d -> %0b at edge %0d", x.sig, x.val, x.e - b);
      end else begin
        y = obs.pop_front();
        if (y.sig !== x.sig || y.val !== x.val || y.e !== x.e) begin
          errors++;
          $display("FAIL event: got sig %0d -> %0b at edge %0d, required sig %0d -> %0b at edge %0d",
                   y.sig, y.val, y.e - b, x.sig, x.val, x.e - b);
        end
      end
    end
    while (obs.size() > 0) begin
      y = obs.pop_front();
      checks++;
      errors++;
      $display("FAIL event_unexpected: sig %0d -> %0b at edge %0d, required none", y.sig, y.val, y.e - b);
    end
  endtask
  task automatic do_reset(input logic lock);
    tick();
    rst = 1'b1;
    lk = lock;
    rq = 1'b0;
    tick();
    @(negedge clk);
    #1;
    obs.delete();
    tick();
    rst = 1'b0;
    b = edge_n;
  endtask
  task automatic test_reset;
    do_reset(1'b0);
    checks++;
    if (w_all !== RST_V) begin errors++; $display("FAIL reset_state: got %h required %h", w_all, RST_V); end
    tick();
    checks++;
    if (w_all !== RST_V) begin errors++; $display("FAIL reset_hold: got %h required %h", w_all, RST_V); end
  endtask
  task automatic test_clean_start;
    do_reset(1'b0);
    expect_ev(0, 1'b0, b + RP);
    expect_ev(1, 1'b0, b + RP + 2 + 3 + ST);
    expect_ev(2, 1'b0, b + RP + 2 + 3 + ST + SG);
    wait_to(b + RP + 2);
    lk = 1'b1;
    wait_to(b + RP + 2 + 3 + ST + SG - 1);
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL clean_ready_early: got %b required 0", o_ready); end
    drain_until(b + RP + 2 + 3 + ST + SG + 2);
    checks++;
    if ({o_ready, o_fault, o_retry_cnt} !== 6'b100000) begin
      errors++;
      $display("FAIL clean_run: got ready/fault/retry %b required 100000", {o_ready, o_fault, o_retry_cnt});
    end
  endtask
  task automatic test_lock_glitch;
    int first, restore, rel;
    do_reset(1'b0);
    first = b + RP + 2;
    restore = b + 12;
    rel = b + RP + 2 + 3 + ST + (restore - first);
    expect_ev(0, 1'b0, b + RP);
    expect_ev(1, 1'b0, rel);
    expect_ev(2, 1'b0, rel + SG);
    wait_to(first);
    lk = 1'b1;
    wait_to(b + 11);
    lk = 1'b0;
    wait_to(restore);
    lk = 1'b1;
    drain_until(rel + SG + 2);
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL glitch_ready: got %b required 1", o_ready); end
  endtask
  task automatic test_never_locks;
    do_reset(1'b0);
    expect_ev(0, 1'b0, b + RP);
    expect_ev(0, 1'b1, b + RP + TO);
    expect_ev(0, 1'b0, b + 2 * RP + TO);
    expect_ev(0, 1'b1, b + 2 * RP + 2 * TO);
    wait_to(b + RP + TO - 1);
    checks++;
    if (o_retry_cnt !== 4'd0) begin errors++; $display("FAIL retry_before_timeout: got %0d required 0", o_retry_cnt); end
    wait_to(b + RP + TO);
    checks++;
    if ({o_retry_cnt, o_fault} !== 5'b00010) begin
      errors++;
      $display("FAIL retry_first: got retry %0d fault %b required 1 0", o_retry_cnt, o_fault);
    end
    wait_to(b + 2 * RP + 2 * TO);
    checks++;
    if ({o_retry_cnt, o_fault} !== 5'b00101) begin
      errors++;
      $display("FAIL retry_fault: got retry %0d fault %b required 2 1", o_retry_cnt, o_fault);
    end
    drain_until(b + 2 * RP + 2 * TO + 8);
    checks++;
    if ({o_pll_rst, o_sys_rst, o_periph_rst, o_fault, o_ready} !== 5'b11110) begin
      errors++;
      $display("FAIL fault_hold: got pll/sys/periph/fault/ready %b required 11110",
               {o_pll_rst, o_sys_rst, o_periph_rst, o_fault, o_ready});
    end
  endtask
  task automatic test_relock_from_fault;
    int r;
    tick();
    rq = 1'b1;
    tick();
    rq = 1'b0;
    r = edge_n;
    checks++;
    if ({o_retry_cnt, o_fault, o_pll_rst} !== 6'b000001) begin
      errors++;
      $display("FAIL relock_clear: got retry %0d fault %b pll %b required 0 0 1", o_retry_cnt, o_fault, o_pll_rst);
    end
    expect_ev(0, 1'b0, r + RP);
    expect_ev(1, 1'b0, r + RP + 2 + 3 + ST);
    expect_ev(2, 1'b0, r + RP + 2 + 3 + ST + SG);
    wait_to(r + RP + 2);
    lk = 1'b1;
    drain_until(r + RP + 2 + 3 + ST + SG + 2);
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL relock_ready: got %b required 1", o_ready); end
  endtask
  task automatic test_unlock_in_run;
    int d;
    d = edge_n;
    lk = 1'b0;
    expect_ev(0, 1'b1, d + 3);
    expect_ev(1, 1'b1, d + 3);
    expect_ev(2, 1'b1, d + 3);
    expect_ev(0, 1'b0, d + 3 + RP);
    wait_to(d + 2);
    checks++;
    if ({o_ready, o_sys_rst} !== 2'b10) begin errors++; $display("FAIL unlock_early: got ready/sys %b required 10", {o_ready, o_sys_rst}); end
    wait_to(d + 3);
    checks++;
    if ({o_unlock_cnt, o_retry_cnt, o_ready} !== 13'b00000001_0000_0) begin
      errors++;
      $display("FAIL unlock_count: got unlock %0d retry %0d ready %b required 1 0 0", o_unlock_cnt, o_retry_cnt, o_ready);
    end
    drain_until(d + 3 + RP + 3);
    expect_ev(0, 1'b1, edge_n + 1);
    rq = 1'b1;
    tick();
    rq = 1'b0;
    checks++;
    if ({o_unlock_cnt, o_retry_cnt} !== 12'b00000001_0000) begin
      errors++;
      $display("FAIL relock_keeps_unlock: got unlock %0d retry %0d required 1 0", o_unlock_cnt, o_retry_cnt);
    end
    drain_until(edge_n + 1);
  endtask
  task automatic test_rst_in_release;
    do_reset(1'b0);
    wait_to(b + RP + 2);
    lk = 1'b1;
    wait_to(b + RP + 2 + 3 + ST + 1);
    checks++;
    if ({o_sys_rst, o_periph_rst} !== 2'b01) begin
      errors++;
      $display("FAIL release_state: got sys/periph %b required 01", {o_sys_rst, o_periph_rst});
    end
    rst = 1'b1;
    tick();
    checks++;
    if (w_all !== RST_V) begin errors++; $display("FAIL rst_in_release: got %h required %h", w_all, RST_V); end
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_clean_start();
    test_lock_glitch();
    test_never_locks();
    test_relock_from_fault();
    test_unlock_in_run();
    test_rst_in_release();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Controls the system PLL (50 MHz reference in, two 143 MHz outputs, one of them phase-shifted) and the reset release that depends on it. Clocked by the free-running reference clock so it keeps working while the PLL is unlocked. Generates the PLL reset pulse, qualifies lock, releases the core and peripheral resets in a fixed order, and restarts the sequence on loss of lock. Per-domain reset synchronizers into the PLL output clocks are outside this block.

## Interface
- RST_PULSE_CYCLES, 16: refclk cycles `pll_rst` is held high per attempt (≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive cycles synchronized lock must stay high before release.
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before an attempt fails.
- RELEASE_STAGGER, 8: cycles between `sys_rst` and `periph_rst` deassertion (≥1).
- MAX_RETRIES, 3: failed attempts allowed before FAULT (1..15).
- refclk  in  1  reference clock, sole clock.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock, asynchronous to refclk.
- relock_req  in  1  single-cycle request to re-run the full sequence.
- pll_rst  out  1  PLL reset, active high.
- sys_rst  out  1  core (CPU/interconnect) reset, active high.
- periph_rst  out  1  peripheral (SDRAM controller, I/O) reset, active high.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_cnt  out  4  failed attempts since the last reset or relock_req.
- unlock_cnt  out  8  loss-of-lock events in RUN; saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (`lock_s`) before any use.
- Reset values: pll_rst=1, sys_rst=1, periph_rst=1, ready=0, fault=0, retry_cnt=0, unlock_cnt=0, state=PULSE, counters=0. `rst` mid-sequence returns all of these immediately.
- PULSE: pll_rst=1. After RST_PULSE_CYCLES, go to WAIT_LOCK.
- WAIT_LOCK: pll_rst=0. If lock_s=1, go to STABLE. If the timeout counter reaches LOCK_TIMEOUT_CYCLES, increment retry_cnt. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to PULSE. If lock_s and timeout occur in the same cycle, lock wins.
- STABLE: count consecutive lock_s=1 cycles. lock_s=0 returns to WAIT_LOCK without resetting the timeout counter; the timeout keeps counting across STABLE. The count reaching LOCK_STABLE_CYCLES goes to RELEASE.
- RELEASE: sys_rst=0 on entry. periph_rst=0 after RELEASE_STAGGER cycles, then go to RUN.
- RUN: ready=1. lock_s=0 asserts sys_rst, periph_rst and pll_rst on the next edge, increments unlock_cnt, and goes to PULSE. It does not touch retry_cnt.
- lock_s=0 during RELEASE is treated as in RUN: same reset assertion and transition to PULSE.
- FAULT: all three resets are held at 1 and fault=1. Only rst or relock_req exits.
- relock_req is honoured in any state: clear retry_cnt, assert all resets, go to PULSE. unlock_cnt is kept. relock_req together with rst: rst wins.
- sys_rst and periph_rst deassert only through RELEASE and assert together. Required order: periph_rst=0 implies sys_rst=0, and sys_rst=0 implies pll_rst=0.

## Timing
- All outputs are registered; none is combinational from inputs.
- Lock-to-decision latency: 2 cycles of synchronizer plus 1 cycle of state register.
- Minimum time from rst release to sys_rst=0: RST_PULSE_CYCLES + 3 + LOCK_STABLE_CYCLES cycles, when lock arrives immediately.
- Loss of lock in RUN: resets high 3 cycles after the pll_locked fall (2 sync + 1).
- Counter widths use $clog2(param+1). The timeout and stable counters clear on every state entry, except that the timeout counter is preserved on STABLE→WAIT_LOCK.

## Structure
- Package `pll_seq_pkg`: state enum (PULSE, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT) and default parameter constants.
- One sub-module, `sync_2ff`: a generic 2-flop bit synchronizer, reusable elsewhere.

## Test plan
Bench parameters: RST_PULSE=4, STABLE=8, TIMEOUT=32, STAGGER=3, MAX_RETRIES=2.
- Clean start: lock rises 2 cycles after pll_rst falls. Required: sys_rst falls at cycle 4+2+3+8 after rst release; periph_rst 3 cycles later; ready=1.
- Lock glitch: lock low 1 cycle during STABLE. Required: the stable count restarts and release is delayed by exactly the lost cycles plus the sync latency.
- Never locks: retry_cnt goes 1 then 2, then fault=1, with 2 pll_rst pulses of 4 cycles each. Resets stay high.
- Loss of lock in RUN: resets high 3 cycles after the drop, unlock_cnt=1, then a new 4-cycle pll_rst pulse.
- relock_req while in FAULT: retry_cnt=0, sequence reruns, ready=1 after normal latency.
- rst asserted in RELEASE with sys_rst=0: all outputs return to reset values on the next edge.
